// File: rtl/vga_timing_pkg.sv
// Shared constants, pattern encoding and the colour-bar table for the
// synthetic VGA source.
package vga_timing_pkg;

  localparam int WIDTH  = 800;
  localparam int HEIGHT = 480;
  localparam int H_FP   = 40;
  localparam int H_SYNC = 48;
  localparam int H_BP   = 40;
  localparam int V_FP   = 13;
  localparam int V_SYNC = 3;
  localparam int V_BP   = 29;
  localparam int BOX    = 32;

  localparam int H_TOTAL      = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = HEIGHT + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = WIDTH + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = HEIGHT + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Counters are kept 10 bits wide so the ramp can always take h_cnt[9:2].
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_BOX     = 2'd3
  } pattern_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [0:7][23:0] BAR_TABLE = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical counters with combinational sync, blank and
// end-of-frame decode of the current counter state.
module vga_timing #(
  parameter int WIDTH  = vga_timing_pkg::WIDTH,
  parameter int HEIGHT = vga_timing_pkg::HEIGHT,
  parameter int H_FP   = vga_timing_pkg::H_FP,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BP   = vga_timing_pkg::H_BP,
  parameter int V_FP   = vga_timing_pkg::V_FP,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BP   = vga_timing_pkg::V_BP
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic [vga_timing_pkg::CNT_W-1:0] h_cnt,
  output logic [vga_timing_pkg::CNT_W-1:0] v_cnt,
  output logic                             hs_n,
  output logic                             vs_n,
  output logic                             blank_n,
  output logic                             first_pixel,
  output logic                             end_of_frame
);
  import vga_timing_pkg::*;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(WIDTH + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(HEIGHT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(WIDTH + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(WIDTH + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(HEIGHT + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(HEIGHT + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(HEIGHT);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             end_of_line;

  always_comb begin
    end_of_line  = (h_cnt_q == H_LAST);
    end_of_frame = end_of_line && (v_cnt_q == V_LAST);
    h_cnt_d      = end_of_line ? '0 : h_cnt_q + CNT_W'(1);
    v_cnt_d      = v_cnt_q;
    if (end_of_frame) begin
      v_cnt_d = '0;
    end else if (end_of_line) begin
      v_cnt_d = v_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt       = h_cnt_q;
  assign v_cnt       = v_cnt_q;
  assign hs_n        = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
  assign vs_n        = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
  assign blank_n     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign first_pixel = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_pattern_source.sv
// Synthetic VGA source: timing generator plus a frame-latched pattern
// select and a single registered output stage for colour and sync.
module vga_pattern_source #(
  parameter int WIDTH  = vga_timing_pkg::WIDTH,
  parameter int HEIGHT = vga_timing_pkg::HEIGHT,
  parameter int H_FP   = vga_timing_pkg::H_FP,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BP   = vga_timing_pkg::H_BP,
  parameter int V_FP   = vga_timing_pkg::V_FP,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BP   = vga_timing_pkg::V_BP,
  parameter int BOX    = vga_timing_pkg::BOX
) (
  input  logic        VGA_CLK,
  input  logic        reset_n,
  input  logic [1:0]  pattern,
  output logic [7:0]  oVGA_R,
  output logic [7:0]  oVGA_G,
  output logic [7:0]  oVGA_B,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_SYNC_N,
  output logic        oVGA_BLANK_N,
  output logic        frame_start,
  output logic [15:0] frame_count
);
  import vga_timing_pkg::*;

  localparam logic [CNT_W-1:0] BAR_W      = CNT_W'(WIDTH / 8);
  localparam logic [CNT_W-1:0] BOX_C      = CNT_W'(BOX);
  localparam logic [CNT_W-1:0] BOX_X_LAST = CNT_W'(WIDTH - BOX);
  localparam logic [CNT_W-1:0] BOX_Y0     = CNT_W'(HEIGHT / 2 - BOX / 2);
  localparam logic [CNT_W-1:0] BOX_Y1     = CNT_W'(HEIGHT / 2 + BOX / 2);
  localparam rgb_t             WHITE      = 24'hFFFFFF;
  localparam rgb_t             BLACK      = 24'h000000;
  localparam rgb_t             BOX_BG     = 24'h000080;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             hs_n, vs_n, blank_n, first_pixel, end_of_frame;

  pattern_t         pat_q, pat_d, pat_cur;
  logic [CNT_W-1:0] box_x_q, box_x_d;
  logic [15:0]      frame_count_q, frame_count_d;
  rgb_t             rgb_q, rgb_d, pixel;
  logic             hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic             frame_start_q, frame_start_d;
  logic [2:0]       bar_idx;
  logic             in_box;

  vga_timing #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP)
  ) u_timing (
    .clk          (VGA_CLK),
    .rst_n        (reset_n),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .hs_n         (hs_n),
    .vs_n         (vs_n),
    .blank_n      (blank_n),
    .first_pixel  (first_pixel),
    .end_of_frame (end_of_frame)
  );

  // Pixel (0,0) uses the live select so the whole frame sees the same pattern.
  always_comb begin
    pat_cur = first_pixel ? pattern_t'(pattern) : pat_q;
    pat_d   = pat_cur;
    bar_idx = 3'(h_cnt / BAR_W);
    in_box  = (h_cnt >= box_x_q) && (h_cnt < box_x_q + BOX_C) &&
              (v_cnt >= BOX_Y0) && (v_cnt < BOX_Y1);
    case (pat_cur)
      PAT_BARS:    pixel = rgb_t'(BAR_TABLE[bar_idx]);
      PAT_RAMP:    pixel = {h_cnt[9:2], h_cnt[9:2], h_cnt[9:2]};
      PAT_CHECKER: pixel = (h_cnt[4] ^ v_cnt[4]) ? WHITE : BLACK;
      PAT_BOX:     pixel = in_box ? WHITE : BOX_BG;
      default:     pixel = BLACK;
    endcase
    rgb_d         = blank_n ? pixel : BLACK;
    hs_d          = hs_n;
    vs_d          = vs_n;
    blank_n_d     = blank_n;
    frame_start_d = first_pixel;
  end

  always_comb begin
    box_x_d       = box_x_q;
    frame_count_d = frame_count_q;
    if (end_of_frame) begin
      box_x_d       = (box_x_q == BOX_X_LAST) ? '0 : box_x_q + CNT_W'(1);
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      pat_q         <= PAT_BARS;
      box_x_q       <= '0;
      frame_count_q <= '0;
      rgb_q         <= BLACK;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pat_q         <= pat_d;
      box_x_q       <= box_x_d;
      frame_count_q <= frame_count_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign oVGA_R       = rgb_q.r;
  assign oVGA_G       = rgb_q.g;
  assign oVGA_B       = rgb_q.b;
  assign oVGA_HS      = hs_q;
  assign oVGA_VS      = vs_q;
  assign oVGA_SYNC_N  = 1'b0;
  assign oVGA_BLANK_N = blank_n_q;
  assign frame_start  = frame_start_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_pattern_source.sv
// Directed bench: a full-size instance for line timing and pixel colours,
// and a shrunken instance for frame-level behaviour within a short run.
module tb_vga_pattern_source;

  // shrunken geometry: 56-cycle lines, 44-line frames, box wraps after x=8
  localparam int SW      = 40;
  localparam int S_HTOT  = 56;
  localparam int S_FRAME = 56 * 44;

  logic clk = 1'b0;
  initial forever #20 clk = ~clk;

  logic        a_rst_n, b_rst_n;
  logic [1:0]  a_pattern, b_pattern;
  logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
  logic        a_hs, a_vs, a_sync_n, a_blank_n, a_fs;
  logic        b_hs, b_vs, b_sync_n, b_blank_n, b_fs;
  logic [15:0] a_fc, b_fc;

  vga_pattern_source dut_full (
    .VGA_CLK(clk), .reset_n(a_rst_n), .pattern(a_pattern),
    .oVGA_R(a_r), .oVGA_G(a_g), .oVGA_B(a_b),
    .oVGA_HS(a_hs), .oVGA_VS(a_vs), .oVGA_SYNC_N(a_sync_n),
    .oVGA_BLANK_N(a_blank_n), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_pattern_source #(
    .WIDTH(40), .HEIGHT(36), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_FP(2), .V_SYNC(3), .V_BP(3), .BOX(32)
  ) dut_small (
    .VGA_CLK(clk), .reset_n(b_rst_n), .pattern(b_pattern),
    .oVGA_R(b_r), .oVGA_G(b_g), .oVGA_B(b_b),
    .oVGA_HS(b_hs), .oVGA_VS(b_vs), .oVGA_SYNC_N(b_sync_n),
    .oVGA_BLANK_N(b_blank_n), .frame_start(b_fs), .frame_count(b_fc)
  );

  typedef struct packed {
    logic [1:0]  pat;
    logic [15:0] x;
    logic [23:0] rgb;
    logic        blank_n;
    logic        hs;
  } vec_t;

  vec_t vecs [$];
  int   total = 0;
  int   bad   = 0;
  int   b_p;
  int   b_fs_cnt;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Reset the full instance, release, and sample the output of pixel (x,0).
  task automatic applyStimulus(input vec_t v);
    a_rst_n   = 1'b0;
    a_pattern = v.pat;
    @(negedge clk);
    a_rst_n = 1'b1;
    repeat (int'(v.x) + 1) @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("pat%0d x%0d rgb", v.pat, v.x), {8'h0, a_r, a_g, a_b}, {8'h0, v.rgb});
    checkOutput($sformatf("pat%0d x%0d blank_n", v.pat, v.x), {31'h0, a_blank_n}, {31'h0, v.blank_n});
    checkOutput($sformatf("pat%0d x%0d hs", v.pat, v.x), {31'h0, a_hs}, {31'h0, v.hs});
  endtask

  task automatic b_release(input logic [1:0] pat);
    b_rst_n   = 1'b0;
    b_pattern = pat;
    @(negedge clk);
    b_rst_n  = 1'b1;
    b_p      = -1;
    b_fs_cnt = 0;
  endtask

  task automatic b_step();
    @(posedge clk);
    @(negedge clk);
    b_p++;
    if (b_fs === 1'b1) b_fs_cnt++;
  endtask

  initial begin
    int blank_hi, hs_lo, vs_lo, first_blank_lo, first_hs_lo, first_vs_lo, rises, fs_cnt;
    logic prev_blank;
    int first_white, white_cnt;
    logic [23:0] last_rgb;

    a_rst_n = 1'b0; b_rst_n = 1'b0; a_pattern = 2'd0; b_pattern = 2'd0;

    vecs.push_back({2'd0, 16'd0,   24'hFFFFFF, 1'b1, 1'b1});
    vecs.push_back({2'd0, 16'd99,  24'hFFFFFF, 1'b1, 1'b1});
    vecs.push_back({2'd0, 16'd100, 24'hFFFF00, 1'b1, 1'b1});
    vecs.push_back({2'd0, 16'd250, 24'h00FFFF, 1'b1, 1'b1});
    vecs.push_back({2'd0, 16'd350, 24'h00FF00, 1'b1, 1'b1});
    vecs.push_back({2'd0, 16'd450, 24'hFF00FF, 1'b1, 1'b1});
    vecs.push_back({2'd0, 16'd550, 24'hFF0000, 1'b1, 1'b1});
    vecs.push_back({2'd0, 16'd650, 24'h0000FF, 1'b1, 1'b1});
    vecs.push_back({2'd0, 16'd799, 24'h000000, 1'b1, 1'b1});
    vecs.push_back({2'd0, 16'd800, 24'h000000, 1'b0, 1'b1});
    vecs.push_back({2'd0, 16'd839, 24'h000000, 1'b0, 1'b1});
    vecs.push_back({2'd0, 16'd840, 24'h000000, 1'b0, 1'b0});
    vecs.push_back({2'd0, 16'd887, 24'h000000, 1'b0, 1'b0});
    vecs.push_back({2'd0, 16'd888, 24'h000000, 1'b0, 1'b1});
    vecs.push_back({2'd1, 16'd3,   24'h000000, 1'b1, 1'b1});
    vecs.push_back({2'd1, 16'd4,   24'h010101, 1'b1, 1'b1});
    vecs.push_back({2'd1, 16'd799, 24'hC7C7C7, 1'b1, 1'b1});
    vecs.push_back({2'd1, 16'd850, 24'h000000, 1'b0, 1'b0});
    vecs.push_back({2'd2, 16'd15,  24'h000000, 1'b1, 1'b1});
    vecs.push_back({2'd2, 16'd16,  24'hFFFFFF, 1'b1, 1'b1});
    vecs.push_back({2'd2, 16'd32,  24'h000000, 1'b1, 1'b1});
    vecs.push_back({2'd2, 16'd48,  24'hFFFFFF, 1'b1, 1'b1});
    vecs.push_back({2'd3, 16'd0,   24'h000080, 1'b1, 1'b1});
    vecs.push_back({2'd3, 16'd500, 24'h000080, 1'b1, 1'b1});
    vecs.push_back({2'd3, 16'd920, 24'h000000, 1'b0, 1'b1});

    // reset state of both instances
    @(negedge clk);
    checkOutput("reset rgb", {8'h0, a_r, a_g, a_b}, 32'h0);
    checkOutput("reset hs/vs/sync/blank/fs", {27'h0, a_hs, a_vs, a_sync_n, a_blank_n, a_fs}, 32'b11000);
    checkOutput("reset frame_count", {16'h0, a_fc}, 32'h0);
    checkOutput("reset small hs/vs/sync/blank/fs", {27'h0, b_hs, b_vs, b_sync_n, b_blank_n, b_fs}, 32'b11000);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // one full line plus the first pixel of the next
    a_rst_n = 1'b0; a_pattern = 2'd0;
    @(negedge clk);
    a_rst_n = 1'b1;
    blank_hi = 0; hs_lo = 0; vs_lo = 0; first_blank_lo = -1; first_hs_lo = -1; fs_cnt = 0;
    for (int k = 0; k <= 928; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 0) checkOutput("line frame_start at pixel 0", {31'h0, a_fs}, 32'h1);
      if (k == 928) checkOutput("line blank_n at next line start", {31'h0, a_blank_n}, 32'h1);
      if (k < 928) begin
        if (a_blank_n) blank_hi++;
        if (!a_hs) hs_lo++;
        if (!a_vs) vs_lo++;
        if (!a_blank_n && first_blank_lo < 0) first_blank_lo = k;
        if (!a_hs && first_hs_lo < 0) first_hs_lo = k;
      end
      if (k > 0 && a_fs) fs_cnt++;
    end
    checkOutput("line blank_n high cycles", blank_hi, 800);
    checkOutput("line hs low cycles", hs_lo, 48);
    checkOutput("line blank_n fall pixel", first_blank_lo, 800);
    checkOutput("line hs delay after blank fall", first_hs_lo - first_blank_lo, 40);
    checkOutput("line vs low cycles", vs_lo, 0);
    checkOutput("line extra frame_start", fs_cnt, 0);

    // asynchronous reset in the middle of a line
    a_rst_n = 1'b0; a_pattern = 2'd0;
    @(negedge clk);
    a_rst_n = 1'b1;
    repeat (401) @(posedge clk);
    @(negedge clk);
    checkOutput("mid-line pixel 400", {8'h0, a_r, a_g, a_b}, 32'hFF00FF);
    #5 a_rst_n = 1'b0;
    #1;
    checkOutput("async reset rgb", {8'h0, a_r, a_g, a_b}, 32'h0);
    checkOutput("async reset hs/vs/blank/fs", {28'h0, a_hs, a_vs, a_blank_n, a_fs}, 32'b1100);
    @(negedge clk);
    a_rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("restart frame_start", {31'h0, a_fs}, 32'h1);
    checkOutput("restart pixel 0", {7'h0, a_blank_n, a_r, a_g, a_b}, 32'h1FFFFFF);
    @(posedge clk);
    @(negedge clk);
    checkOutput("restart frame_start falls", {31'h0, a_fs}, 32'h0);
    a_rst_n = 1'b0;

    // small instance: one frame of bars with a mid-frame switch to checker
    b_release(2'd0);
    vs_lo = 0; first_vs_lo = -1; rises = 0; fs_cnt = 0; prev_blank = 1'b0;
    while (b_p < S_FRAME + 16 * S_HTOT + 16) begin
      b_step();
      if (b_p < S_FRAME) begin
        if (!b_vs) vs_lo++;
        if (!b_vs && first_vs_lo < 0) first_vs_lo = b_p;
        if (b_blank_n && !prev_blank) rises++;
        if (b_fs) fs_cnt++;
        prev_blank = b_blank_n;
      end
      if (b_p == 20 * S_HTOT) b_pattern = 2'd2;
      if (b_p == 25 * S_HTOT + 16)
        checkOutput("bars kept after switch", {8'h0, b_r, b_g, b_b}, 32'h00FF00);
      if (b_p == S_FRAME) begin
        checkOutput("second frame_start", {31'h0, b_fs}, 32'h1);
        checkOutput("frame_count after 1 frame", {16'h0, b_fc}, 32'h1);
      end
      if (b_p == S_FRAME + 16)
        checkOutput("checker (16,0)", {8'h0, b_r, b_g, b_b}, 32'hFFFFFF);
      if (b_p == S_FRAME + 16 * S_HTOT + 16)
        checkOutput("checker (16,16)", {8'h0, b_r, b_g, b_b}, 32'h000000);
    end
    checkOutput("frame vs low cycles", vs_lo, 3 * S_HTOT);
    checkOutput("frame vs start line", first_vs_lo, 38 * S_HTOT);
    checkOutput("frame active lines", rises, 36);
    checkOutput("frame_start per frame", fs_cnt, 1);

    // moving box over ten frames: x steps 0..8 then wraps to 0
    b_release(2'd3);
    for (int f = 0; f < 10; f++) begin
      while (b_p < f * S_FRAME) b_step();
      checkOutput($sformatf("frame_count at frame %0d", f), {16'h0, b_fc}, f);
      while (b_p < f * S_FRAME + 2 * S_HTOT) b_step();
      first_white = -1; white_cnt = 0; last_rgb = 24'h0;
      for (int x = 0; x < SW; x++) begin
        if (x > 0) b_step();
        last_rgb = {b_r, b_g, b_b};
        if (last_rgb == 24'hFFFFFF) begin
          white_cnt++;
          if (first_white < 0) first_white = x;
        end
      end
      checkOutput($sformatf("box_x frame %0d", f), first_white, f % 9);
      checkOutput($sformatf("box width frame %0d", f), white_cnt, 32);
      if (f == 0) checkOutput("box background", {8'h0, last_rgb}, 32'h000080);
    end
    while (b_p < 10 * S_FRAME) b_step();
    checkOutput("frame_start pulses over 10 frames", b_fs_cnt, 11);
    checkOutput("frame_count after 10 frames", {16'h0, b_fc}, 32'd10);

    // asynchronous reset mid-frame clears frame_count
    while (b_p < 10 * S_FRAME + 20 * S_HTOT + 10) b_step();
    #5 b_rst_n = 1'b0;
    #1;
    checkOutput("small async reset frame_count", {16'h0, b_fc}, 32'h0);
    checkOutput("small async reset outputs", {4'h0, b_hs, b_vs, b_blank_n, b_fs, b_r, b_g, b_b}, 32'hC000000);
    @(negedge clk);
    b_rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("small restart pixel 0", {6'h0, b_fs, b_blank_n, b_r, b_g, b_b}, 32'h3000080);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
